// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle divider and the
// EX-stage stall handshake that surrounds it.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;
   localparam int DIV_CNT_W  = 6;

   // Reset is asserted low throughout the pipeline.
   localparam logic RSTENABLE = 1'b0;

   // EX raises STOP on stallreq_ex while a division is outstanding.
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the signs of the quotient and remainder.
module div_abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         neg,
   output logic [W-1:0] result
);

   assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Optional build macro DIV_EARLY_EXIT_EN: finish on edge 1 when |dividend| < |divisor|.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int WORK_W = 2*DATA_W + 1;

   div_state_e           state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [WORK_W-1:0]    work, work_next;
   logic [DATA_W-1:0]    divisor_q, divisor_next;
   logic                 quot_neg_q, quot_neg_next;
   logic                 rem_neg_q, rem_neg_next;
   logic [2*DATA_W-1:0]  result_next;
   logic                 ready_next;

   logic                 dividend_neg, divisor_neg;
   logic [DATA_W-1:0]    dividend_abs, divisor_abs;
   logic                 early_exit;

   logic [WORK_W-1:0]    work_shift, work_iter;
   logic [DATA_W+1:0]    diff;
   logic [DATA_W-1:0]    quot_fix, rem_fix;

   assign dividend_neg = signed_div_i & opdata1_i[DATA_W-1];
   assign divisor_neg  = signed_div_i & opdata2_i[DATA_W-1];

   div_abs_neg #(.W(DATA_W)) u_abs_dividend (
      .value  (opdata1_i),
      .neg    (dividend_neg),
      .result (dividend_abs)
   );

   div_abs_neg #(.W(DATA_W)) u_abs_divisor (
      .value  (opdata2_i),
      .neg    (divisor_neg),
      .result (divisor_abs)
   );

`ifdef DIV_EARLY_EXIT_EN
   assign early_exit = (dividend_abs < divisor_abs);
`else
   assign early_exit = 1'b0;
`endif

   // One restoring step: diff is two bits wider than the divisor so its MSB
   // is a clean borrow flag telling whether the trial subtraction fits.
   assign work_shift = {work[WORK_W-2:0], 1'b0};
   assign diff       = {1'b0, work_shift[WORK_W-1:DATA_W]} - {2'b00, divisor_q};
   assign work_iter  = diff[DATA_W+1] ? work_shift
                                      : {diff[DATA_W:0], work_shift[DATA_W-1:1], 1'b1};

   div_abs_neg #(.W(DATA_W)) u_fix_quot (
      .value  (work_iter[DATA_W-1:0]),
      .neg    (quot_neg_q),
      .result (quot_fix)
   );

   div_abs_neg #(.W(DATA_W)) u_fix_rem (
      .value  (work_iter[2*DATA_W-1:DATA_W]),
      .neg    (rem_neg_q),
      .result (rem_fix)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      work_next     = work;
      divisor_next  = divisor_q;
      quot_neg_next = quot_neg_q;
      rem_neg_next  = rem_neg_q;
      result_next   = result_o;
      ready_next    = ready_o;

      unique case (state)
         DIV_FREE: begin
            result_next = '0;
            ready_next  = DIV_RESULT_NOT_READY;
            if (start_i == DIV_START && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_next = DIV_BYZERO;
               end else if (early_exit) begin
                  state_next  = DIV_END;
                  result_next = {opdata1_i, {DATA_W{1'b0}}};
                  ready_next  = DIV_RESULT_READY;
               end else begin
                  state_next    = DIV_ON;
                  cnt_next      = '0;
                  work_next     = {{(DATA_W+1){1'b0}}, dividend_abs};
                  divisor_next  = divisor_abs;
                  quot_neg_next = dividend_neg ^ divisor_neg;
                  rem_neg_next  = dividend_neg;
               end
            end
         end

         DIV_BYZERO: begin
            state_next  = DIV_END;
            result_next = '0;
            ready_next  = DIV_RESULT_READY;
         end

         DIV_ON: begin
            if (annul_i) begin
               state_next  = DIV_FREE;
               result_next = '0;
               ready_next  = DIV_RESULT_NOT_READY;
            end else begin
               work_next = work_iter;
               cnt_next  = cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_W-1)) begin
                  state_next  = DIV_END;
                  result_next = {rem_fix, quot_fix};
                  ready_next  = DIV_RESULT_READY;
               end
            end
         end

         DIV_END: begin
            if (start_i == DIV_STOP) begin
               state_next  = DIV_FREE;
               result_next = '0;
               ready_next  = DIV_RESULT_NOT_READY;
            end
         end

         default: state_next = DIV_FREE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RSTENABLE) begin
         state      <= DIV_FREE;
         cnt        <= '0;
         work       <= '0;
         divisor_q  <= '0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         result_o   <= '0;
         ready_o    <= DIV_RESULT_NOT_READY;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         work       <= work_next;
         divisor_q  <= divisor_next;
         quot_neg_q <= quot_neg_next;
         rem_neg_q  <= rem_neg_next;
         result_o   <= result_next;
         ready_o    <= ready_next;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed correction,
// divide-by-zero, annul, asynchronous reset and the early-exit path.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one operation, confirm exact latency, hold, then release.
   task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      wait_edges(1);
      opdata1 = $urandom;
      opdata2 = $urandom;
      if (lat > 1) begin
         if (lat > 2) wait_edges(lat - 2);
         check({tag, " not_ready_before"}, {63'b0, ready}, 64'd0);
         wait_edges(1);
      end
      check({tag, " ready"}, {63'b0, ready}, 64'd1);
      check({tag, " result"}, result, exp);
      wait_edges(1);
      check({tag, " hold_ready"}, {63'b0, ready}, 64'd1);
      check({tag, " hold_result"}, result, exp);
      start = 1'b0;
      wait_edges(1);
      check({tag, " release_ready"}, {63'b0, ready}, 64'd0);
      check({tag, " release_result"}, result, 64'd0);
   endtask

   initial begin
      logic rose;
      rst        = 1'b0;
      signed_div = 1'b0;
      opdata1    = '0;
      opdata2    = '0;
      start      = 1'b0;
      annul      = 1'b0;

      wait_edges(2);
      check("reset ready", {63'b0, ready}, 64'd0);
      check("reset result", result, 64'd0);
      rst = 1'b1;
      wait_edges(1);

      run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
      run_op("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 33, 64'hFFFFFFFE_FFFFFFF2);
      run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 33, 64'h00000002_FFFFFFF2);
      run_op("div_5_0", 1'b1, 32'd5, 32'd0, 2, 64'd0);
      run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);

      // A start qualified by annul must not leave FREE.
      signed_div = 1'b0;
      opdata1    = 32'd5;
      opdata2    = 32'd0;
      start      = 1'b1;
      annul      = 1'b1;
      wait_edges(3);
      check("annul_in_free ready", {63'b0, ready}, 64'd0);
      start = 1'b0;
      annul = 1'b0;
      wait_edges(1);

      // Annul during the 10th ON cycle, then confirm ready never appears.
      opdata1 = 32'd50;
      opdata2 = 32'd5;
      start   = 1'b1;
      wait_edges(10);
      annul = 1'b1;
      wait_edges(1);
      annul = 1'b0;
      start = 1'b0;
      check("annul ready", {63'b0, ready}, 64'd0);
      check("annul result", result, 64'd0);
      rose = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wait_edges(1);
         if (ready) rose = 1'b1;
      end
      check("annul ready_never_rose", {63'b0, rose}, 64'd0);
      run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

      // Asynchronous reset partway through the iterations.
      opdata1 = 32'd1234;
      opdata2 = 32'd5;
      start   = 1'b1;
      wait_edges(21);
      #2;
      rst   = 1'b0;
      start = 1'b0;
      #1;
      check("reset_mid ready", {63'b0, ready}, 64'd0);
      check("reset_mid result", result, 64'd0);
      wait_edges(1);
      rst = 1'b1;
      wait_edges(1);
      run_op("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, 64'h00000000_FFFFFFFF);

      // Asynchronous reset while a result is being held.
      opdata1 = 32'd77;
      opdata2 = 32'd0;
      start   = 1'b1;
      wait_edges(2);
      check("reset_end pre ready", {63'b0, ready}, 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("reset_end ready", {63'b0, ready}, 64'd0);
      check("reset_end result", result, 64'd0);
      start = 1'b0;
      wait_edges(1);
      rst = 1'b1;
      wait_edges(1);

`ifdef DIV_EARLY_EXIT_EN
      run_op("divu_3_9", 1'b0, 32'd3, 32'd9, 1, 64'h00000003_00000000);
      run_op("div_m3_9", 1'b1, 32'hFFFFFFFD, 32'd9, 1, 64'hFFFFFFFD_00000000);
`else
      run_op("divu_3_9", 1'b0, 32'd3, 32'd9, 33, 64'h00000003_00000000);
      run_op("div_m3_9", 1'b1, 32'hFFFFFFFD, 32'd9, 33, 64'hFFFFFFFD_00000000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU; sits beside the EX stage and feeds it.
- EX drives `start_i`. While `start_i`=1 and `ready_o`=0, EX raises `stallreq_ex`, and the stall controller freezes PC/IF/ID/EX.
- On completion the result goes back to EX for HI/LO writeback.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; held high by EX until `ready_o` is seen.
- annul_i  in  1  abort the current operation (exception or flush in later stages).
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.

Behaviour:
- **Reset.** rst=0 at any time, including mid-operation, forces state FREE, `result_o`=0, `ready_o`=0, counter=0 and the work register=0. Takes effect immediately, without waiting for a clock edge.
- **FREE state.**
  - start_i=1, annul_i=0, divisor==0 → BYZERO.
  - start_i=1, annul_i=0, divisor!=0 → ON. Operands are latched: for signed ops with a negative operand, its two's-complement magnitude is latched; the signs are latched separately. Work register is 65 bits, {33'b0, |dividend|}; counter=0.
  - start_i=0 or annul_i=1 → stay in FREE.
- **BYZERO state.** Next edge → END with `result_o`=0 and `ready_o`=1.
- **ON state.** One iteration per edge:
  - Shift the work register left by 1.
  - diff = upper33 − {1'b0,|divisor|}.
  - If diff ≥ 0, upper33 = diff and LSB = 1; otherwise LSB = 0.
  - counter++.
  - annul_i=1 in any ON cycle → FREE; `ready_o` stays 0 and `result_o` stays 0.
  - The edge performing the 32nd iteration (counter==31) enters END. On that edge it registers the sign-corrected result and sets `ready_o`=1.
- **Sign correction (signed ops only).**
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps; no trap).
- **END state.**
  - `ready_o`=1 and `result_o` are held while start_i=1.
  - When start_i=0 is sampled → FREE, with `ready_o`=0 and `result_o`=0 on that edge.
  - annul_i is ignored in END.
- **Latency** (edge 1 = the edge that samples start_i=1 in FREE):
  - Normal: `ready_o` is high after edge 33.
  - Divide-by-zero: `ready_o` is high after edge 2.
- **Back-to-back operations.** The next operation is accepted only from FREE, so at least one cycle with start_i=0 is required between operations.
- **Operand stability.** Operand inputs are don't-care after edge 1.

Optional Feature:
- Macro: `DIV_EARLY_EXIT_EN`.
- Defined: in FREE, on start with divisor!=0 and |dividend| < |divisor| (unsigned magnitude compare), go directly to END on edge 1. Result is quotient=0, remainder=original dividend (sign preserved). `ready_o` is high after edge 1.
- Undefined: such operands take the full 33-edge path and produce the identical result.

Decomposition:
- The shared defines file gains:
  - State encodings DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2 bits).
  - DIV_START/DIV_STOP.
  - DIV_RESULT_READY/DIV_RESULT_NOT_READY.
  - The existing RSTENABLE usage, re-expressed as active-low.
- The existing STOP constant remains what EX uses for `stallreq_ex`.
- A single module is natural. An optional helper sub-module, div_abs_neg, provides conditional two's-complement negation and is reused for operand magnitude and result correction.

Test Plan:
- **Unsigned:** DIVU 100/7, start held → `ready_o`=1 after edge 33, `result_o`=0x00000002_0000000E; drop start → `ready_o`=0, `result_o`=0 next edge.
- **Signed:** DIV −100/7 (0xFFFFFF9C/7) → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. DIV 100/−7 → quotient 0xFFFFFFF2, remainder 0x00000002.
- **Divide by zero:** DIV 5/0 → `ready_o`=1 after edge 2, `result_o`=0. DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- **Annul:** annul_i=1 at the 10th ON cycle → FREE next edge, `ready_o` never rises. Restart DIVU 9/3 → `result_o`=0x00000000_00000003 after edge 33.
- **Reset mid-operation:** assert rst=0 asynchronously mid-operation at iteration 20 → outputs 0 before the next clock edge. Release and run DIVU 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- **Early exit:** with `DIV_EARLY_EXIT_EN`, DIVU 3/9 → `ready_o` after edge 1, `result_o`=0x00000003_00000000. Without the macro, the same result arrives after edge 33.
